// File: rtl/regfile_pkg.sv
// Shared types, constants and helpers for the multiport register file.
package regfile_pkg;

  // ZERO_REG value meaning "no hard-zero register"
  localparam int NO_ZERO_REG = -1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } clr_state_t;

  // Ceiling log2, never less than 1 so counters and indices stay at least one bit wide
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return (r == 0) ? 1 : r;
  endfunction

  // Address names a real, writable/readable register: in range and not the hard-zero one.
  // The full address is compared, so upper bits are never silently dropped.
  function automatic logic addr_ok(input logic [31:0] addr, input int unsigned depth,
                                   input int zero_reg);
    logic is_zero;
    is_zero = (zero_reg >= 0) && (addr == $unsigned(zero_reg));
    return (addr < depth) && !is_zero;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One read port: range/zero masking, array mux, write bypass and optional output register.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AW       = 8,
  parameter int          ZERO_REG = 15,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned READ_LAT = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DEPTH*WIDTH-1:0]   mem_flat_i,
  input  logic [AW-1:0]            r_addr_i,
  input  logic                     wr_acc_i,
  input  logic [AW-1:0]            wr_addr_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  output logic [WIDTH-1:0]         r_data_o
);

  logic             valid_c;
  logic             hit_c;
  logic [WIDTH-1:0] arr_c;
  logic [WIDTH-1:0] plain_c;
  logic [WIDTH-1:0] byp_c;
  logic [WIDTH-1:0] rd_q;

  // Array lookup plus the two views: plain array contents and write-forwarded contents
  always_comb begin
    arr_c   = '0;
    valid_c = addr_ok(32'(r_addr_i), DEPTH, ZERO_REG);
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (32'(r_addr_i) == 32'(i)) arr_c = mem_flat_i[i*WIDTH +: WIDTH];
    end
    // Only accepted writes arrive on wr_acc_i, so dropped writes can never be forwarded
    hit_c   = wr_acc_i && (wr_addr_i == r_addr_i);
    plain_c = valid_c ? arr_c : '0;
    byp_c   = valid_c ? (hit_c ? wr_data_i : arr_c) : '0;
  end

  // Registered read always captures the forwarded view, so it reflects the write at the same edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_q <= '0;
    else      rd_q <= byp_c;
  end

  assign r_data_o = (READ_LAT != 0) ? rd_q : ((BYPASS != 0) ? byp_c : plain_c);

endmodule

// File: rtl/regfile_multiport_clr.sv
// DEPTH x WIDTH register file with NRD read ports, one write port and a handshaked clear sweep.
module regfile_multiport_clr
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned NRD      = 2,
  parameter int          ZERO_REG = 15,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned READ_LAT = 0,
  parameter int unsigned AW       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 w_en,
  input  logic [AW-1:0]        w_addr,
  input  logic [WIDTH-1:0]     w_data,
  input  logic [NRD*AW-1:0]    r_addr,
  output logic [NRD*WIDTH-1:0] r_data,
  input  logic                 clr_req,
  output logic                 clr_busy,
  output logic                 clr_done,
  output logic                 w_drop
);

  localparam int unsigned CW = clog2(DEPTH);

  clr_state_t              state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    clr_busy_q, clr_busy_d;
  logic                    clr_done_q, clr_done_d;
  logic                    w_drop_q, w_drop_d;
  logic                    sweep_c;
  logic                    wr_acc_c;
  logic [DEPTH*WIDTH-1:0]  mem_flat;

  // Clear FSM next state, write acceptance and next values of the registered flags
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sweep_c  = (state_q == SWEEP);
    wr_acc_c = w_en && (state_q == IDLE) && addr_ok(32'(w_addr), DEPTH, ZERO_REG);
    unique case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        if (cnt_q == CW'(DEPTH - 1)) state_d = DONE;
        else                         cnt_d   = cnt_q + CW'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    clr_busy_d = (state_d == SWEEP);
    clr_done_d = (state_d == DONE);
    w_drop_d   = w_en && !wr_acc_c;
  end

  // FSM state, sweep counter and output flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
      w_drop_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clr_busy_q <= clr_busy_d;
      clr_done_q <= clr_done_d;
      w_drop_q   <= w_drop_d;
    end
  end

  assign clr_busy = clr_busy_q;
  assign clr_done = clr_done_q;
  assign w_drop   = w_drop_q;

  // Storage: one register per entry; the sweep and external writes never coincide
  for (genvar i = 0; i < int'(DEPTH); i++) begin : g_reg
    logic [WIDTH-1:0] reg_q;

    // Entry update: sweep clear has priority, then an accepted external write
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                        reg_q <= '0;
      else if (sweep_c && (cnt_q == CW'(i)))           reg_q <= '0;
      else if (wr_acc_c && (32'(w_addr) == 32'(i)))    reg_q <= w_data;
    end

    assign mem_flat[i*WIDTH +: WIDTH] = reg_q;
  end

  for (genvar k = 0; k < int'(NRD); k++) begin : g_rd
    regfile_read_port #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .AW       (AW),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS),
      .READ_LAT (READ_LAT)
    ) u_rd (
      .clk        (clk),
      .rst        (rst),
      .mem_flat_i (mem_flat),
      .r_addr_i   (r_addr[k*AW +: AW]),
      .wr_acc_i   (wr_acc_c),
      .wr_addr_i  (w_addr),
      .wr_data_i  (w_data),
      .r_data_o   (r_data[k*WIDTH +: WIDTH])
    );
  end

endmodule
